// File: rtl/spm_share_arbiter_pkg.sv
// Shared types and defaults for the serial-multiplier share arbiter.
// Provides the FSM encoding and a helper for index and counter widths.
package spm_share_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2,
      RESP = 2'd3
   } state_e;

   localparam int N_REQ_DEF   = 4;
   localparam int W_DEF       = 8;
   localparam int TIMEOUT_DEF = 32;

   function automatic int clog2_min1(input int v);
      return (v <= 2) ? 1 : $clog2(v);
   endfunction

endpackage

// File: rtl/spm_share_arbiter_if.sv
// Requester-side request/response channels of the share arbiter.
// The master modport is the requester pool, the slave is the arbiter.
interface spm_share_arbiter_if
   import spm_share_arbiter_pkg::*;
#(
   parameter int N_REQ = N_REQ_DEF,
   parameter int W     = W_DEF
);

   logic [N_REQ-1:0]   req_valid;
   logic [N_REQ-1:0]   req_ready;
   logic [N_REQ*W-1:0] req_x;
   logic [N_REQ*W-1:0] req_y;
   logic [N_REQ-1:0]   rsp_valid;
   logic [N_REQ-1:0]   rsp_ready;
   logic [2*W-1:0]     rsp_prod;
   logic               rsp_err;

   modport master (
      output req_valid, req_x, req_y, rsp_ready,
      input  req_ready, rsp_valid, rsp_prod, rsp_err
   );

   modport slave (
      input  req_valid, req_x, req_y, rsp_ready,
      output req_ready, rsp_valid, rsp_prod, rsp_err
   );

endinterface

// File: rtl/spm_share_arbiter_rr_pick.sv
// Combinational round-robin picker: first request at or above ptr,
// searching upward and wrapping.
module spm_share_arbiter_rr_pick #(
   parameter int N_REQ = 4,
   parameter int IW    = 2
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IW-1:0]    ptr,
   output logic [N_REQ-1:0] gnt,
   output logic [IW-1:0]    idx,
   output logic             any
);

   int          j;
   logic [IW-1:0] jj;

   always_comb begin
      gnt = '0;
      idx = '0;
      any = 1'b0;
      j   = 0;
      jj  = '0;
      for (int k = 0; k < N_REQ; k++) begin
         j  = (int'(ptr) + k) % N_REQ;
         jj = IW'(j);
         if (!any && req[jj]) begin
            any     = 1'b1;
            idx     = jj;
            gnt[jj] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/spm_share_arbiter.sv
// Shares one restart-by-reset serial multiplier among N_REQ requesters,
// with round-robin grant and a watchdog for jobs that never finish.
module spm_share_arbiter
   import spm_share_arbiter_pkg::*;
#(
   parameter int N_REQ   = N_REQ_DEF,
   parameter int W       = W_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic           clk,
   input  logic           rst_n,
   spm_share_arbiter_if.slave bus,
   output logic           mul_rst,
   output logic [W-1:0]   mul_x,
   output logic [W-1:0]   mul_y,
   input  logic [2*W-1:0] mul_prod,
   input  logic           mul_done,
   output logic           busy
);

   localparam int IW = clog2_min1(N_REQ);
   localparam int CW = clog2_min1(TIMEOUT);

   state_e         state_q, state_d;
   logic [IW-1:0]  ptr_q, ptr_d;
   logic [IW-1:0]  own_q, own_d;
   logic [W-1:0]   mx_q, mx_d;
   logic [W-1:0]   my_q, my_d;
   logic [2*W-1:0] prod_q, prod_d;
   logic           err_q, err_d;
   logic [CW-1:0]  cnt_q, cnt_d;

   logic [N_REQ-1:0] gnt;
   logic [IW-1:0]    pick;
   logic             any;
   logic             idle;

   spm_share_arbiter_rr_pick #(
      .N_REQ (N_REQ),
      .IW    (IW)
   ) u_pick (
      .req (bus.req_valid),
      .ptr (ptr_q),
      .gnt (gnt),
      .idx (pick),
      .any (any)
   );

   assign idle = (state_q == IDLE);

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      own_d   = own_q;
      mx_d    = mx_q;
      my_d    = my_q;
      prod_d  = prod_q;
      err_d   = err_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (any) begin
               own_d   = pick;
               mx_d    = bus.req_x[pick*W +: W];
               my_d    = bus.req_y[pick*W +: W];
               ptr_d   = (pick == IW'(N_REQ-1)) ? '0 : pick + 1'b1;
               state_d = LOAD;
            end
         end
         LOAD: begin
            cnt_d   = '0;
            state_d = RUN;
         end
         RUN: begin
            if (mul_done) begin
               prod_d  = mul_prod;
               err_d   = 1'b0;
               state_d = RESP;
            end else if (cnt_q == CW'(TIMEOUT-1)) begin
               prod_d  = '0;
               err_d   = 1'b1;
               state_d = RESP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         RESP: begin
            if (bus.rsp_ready[own_q]) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         own_q   <= '0;
         mx_q    <= '0;
         my_q    <= '0;
         prod_q  <= '0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         own_q   <= own_d;
         mx_q    <= mx_d;
         my_q    <= my_d;
         prod_q  <= prod_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   // Grant is gated by rst_n: state reads IDLE during reset.
   assign bus.req_ready = (idle && rst_n) ? gnt : '0;
   assign bus.rsp_valid = (state_q == RESP)
                        ? ({{(N_REQ-1){1'b0}}, 1'b1} << own_q)
                        : '0;
   assign bus.rsp_prod  = prod_q;
   assign bus.rsp_err   = err_q;
   assign mul_x         = mx_q;
   assign mul_y         = my_q;
   assign mul_rst       = ~rst_n | (state_q == LOAD);
   assign busy          = ~idle;

endmodule

// File: tb/tb_spm_share_arbiter.sv
// Directed bench for the share arbiter with a behavioural
// restart-by-reset serial multiplier (done 9 edges after restart).
module tb_spm_share_arbiter;
   import spm_share_arbiter_pkg::*;

   localparam int N  = 4;
   localparam int W  = 8;
   localparam int TO = 32;

   logic           clk   = 1'b0;
   logic           rst_n = 1'b0;
   logic           mul_rst;
   logic [W-1:0]   mul_x;
   logic [W-1:0]   mul_y;
   logic [2*W-1:0] mul_prod;
   logic           mul_done;
   logic           busy;

   logic           m_done_q;
   logic [3:0]     m_cnt;
   logic           kill = 1'b0;

   int n_tests = 0;
   int n_fail  = 0;

   spm_share_arbiter_if #(.N_REQ(N), .W(W)) bus ();

   spm_share_arbiter #(
      .N_REQ   (N),
      .W       (W),
      .TIMEOUT (TO)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .bus      (bus),
      .mul_rst  (mul_rst),
      .mul_x    (mul_x),
      .mul_y    (mul_y),
      .mul_prod (mul_prod),
      .mul_done (mul_done),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   // Serial multiplier: 8 steps after restart, done sticky until restart.
   always @(posedge clk) begin
      if (mul_rst) begin
         m_cnt    <= '0;
         m_done_q <= 1'b0;
         mul_prod <= '0;
      end else if (!m_done_q) begin
         m_cnt <= m_cnt + 1'b1;
         if (m_cnt == 4'd7) begin
            m_done_q <= 1'b1;
            mul_prod <= $signed(mul_x) * $signed(mul_y);
         end
      end
   end

   assign mul_done = m_done_q & ~kill;

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish");
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] p16(input int v);
      logic [15:0] t;
      t = v[15:0];
      return {16'h0, t};
   endfunction

   function automatic logic [31:0] b8(input int v);
      logic [7:0] t;
      t = v[7:0];
      return {24'h0, t};
   endfunction

   task automatic set_req(input int i, input int x, input int y);
      bus.req_x[i*W +: W] = x[7:0];
      bus.req_y[i*W +: W] = y[7:0];
      bus.req_valid[i]    = 1'b1;
   endtask

   task automatic serve(input int i, input int x, input int y,
                        input int ep, input int ee, input int el,
                        input bit hold, input string tag);
      int   lat;
      logic r1;
      #1;
      chk({tag, ".gnt"}, {28'h0, bus.req_ready}, 32'(1 << i));
      tick();
      if (!hold) bus.req_valid[i] = 1'b0;
      chk({tag, ".mrst"}, {31'h0, mul_rst}, 32'd1);
      chk({tag, ".busy"}, {31'h0, busy}, 32'd1);
      chk({tag, ".mx"}, {24'h0, mul_x}, b8(x));
      chk({tag, ".my"}, {24'h0, mul_y}, b8(y));
      lat = 0;
      r1  = 1'b1;
      for (int k = 1; k <= 100; k++) begin
         tick();
         if (k == 1) r1 = mul_rst;
         if (bus.rsp_valid != '0) begin
            lat = k;
            break;
         end
      end
      chk({tag, ".mrst1"}, {31'h0, r1}, 32'd0);
      chk({tag, ".lat"}, 32'(lat), 32'(el));
      chk({tag, ".vld"}, {28'h0, bus.rsp_valid}, 32'(1 << i));
      chk({tag, ".prod"}, {16'h0, bus.rsp_prod}, p16(ep));
      chk({tag, ".err"}, {31'h0, bus.rsp_err}, 32'(ee));
   endtask

   task automatic finish_job(input string tag);
      tick();
      chk({tag, ".idle"}, {31'h0, busy}, 32'd0);
      chk({tag, ".vld0"}, {28'h0, bus.rsp_valid}, 32'd0);
   endtask

   int tx[4] = '{3, -2, 127, -128};
   int ty[4] = '{4, 6, -128, -128};
   int tp[4] = '{12, -12, -16256, 16384};

   initial begin
      bus.req_valid = '0;
      bus.req_x     = '0;
      bus.req_y     = '0;
      bus.rsp_ready = '1;
      rst_n         = 1'b0;

      // Reset: a pending request must not be granted.
      repeat (3) tick();
      bus.req_valid[0] = 1'b1;
      #1;
      chk("rst.ready", {28'h0, bus.req_ready}, 32'd0);
      chk("rst.busy", {31'h0, busy}, 32'd0);
      chk("rst.vld", {28'h0, bus.rsp_valid}, 32'd0);
      chk("rst.prod", {16'h0, bus.rsp_prod}, 32'd0);
      chk("rst.err", {31'h0, bus.rsp_err}, 32'd0);
      chk("rst.mx", {24'h0, mul_x}, 32'd0);
      chk("rst.my", {24'h0, mul_y}, 32'd0);
      chk("rst.mrst", {31'h0, mul_rst}, 32'd1);
      bus.req_valid = '0;
      rst_n = 1'b1;
      tick();
      chk("rel.mrst", {31'h0, mul_rst}, 32'd0);

      // 1: single job
      set_req(0, -7, 5);
      serve(0, -7, 5, -35, 0, 10, 0, "t1");
      finish_job("t1");

      // Re-reset so the pointer starts from 0.
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();

      // 2: all four valid, round-robin order
      for (int i = 0; i < 4; i++) set_req(i, tx[i], ty[i]);
      for (int i = 0; i < 4; i++) begin
         serve(i, tx[i], ty[i], tp[i], 0, 10, 0, "t2");
         finish_job("t2");
      end

      // 3: back-pressure on requester 1, requester 2 waiting
      bus.rsp_ready = 4'b1101;
      set_req(1, 5, -9);
      set_req(2, -6, -7);
      serve(1, 5, -9, -45, 0, 10, 0, "t3a");
      for (int c = 0; c < 20; c++) begin
         tick();
         chk("t3.hold.prod", {16'h0, bus.rsp_prod}, p16(-45));
         chk("t3.hold.err", {31'h0, bus.rsp_err}, 32'd0);
         chk("t3.hold.vld", {28'h0, bus.rsp_valid}, 32'h2);
         chk("t3.hold.rdy", {28'h0, bus.req_ready}, 32'd0);
      end
      bus.rsp_ready[1] = 1'b1;
      tick();
      chk("t3.next.gnt", {28'h0, bus.req_ready}, 32'h4);
      serve(2, -6, -7, 42, 0, 10, 0, "t3b");
      finish_job("t3b");

      // 4: watchdog abort, then a normal job
      kill = 1'b1;
      set_req(3, 10, 10);
      serve(3, 10, 10, 0, 1, 33, 0, "t4a");
      finish_job("t4a");
      kill = 1'b0;
      set_req(0, 3, -4);
      serve(0, 3, -4, -12, 0, 10, 0, "t4b");
      finish_job("t4b");

      // 5: reset mid-RUN
      set_req(1, 9, 9);
      #1;
      tick();
      bus.req_valid[1] = 1'b0;
      bus.req_valid[2] = 1'b1;
      repeat (3) tick();
      chk("t5.run", {31'h0, busy}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("t5.busy", {31'h0, busy}, 32'd0);
      chk("t5.vld", {28'h0, bus.rsp_valid}, 32'd0);
      chk("t5.rdy", {28'h0, bus.req_ready}, 32'd0);
      chk("t5.prod", {16'h0, bus.rsp_prod}, 32'd0);
      chk("t5.err", {31'h0, bus.rsp_err}, 32'd0);
      chk("t5.mx", {24'h0, mul_x}, 32'd0);
      chk("t5.mrst", {31'h0, mul_rst}, 32'd1);
      repeat (12) tick();
      chk("t5.novld", {28'h0, bus.rsp_valid}, 32'd0);
      bus.req_valid = '0;
      rst_n = 1'b1;
      tick();
      chk("t5.rel", {31'h0, busy}, 32'd0);
      set_req(1, 2, -3);
      serve(1, 2, -3, -6, 0, 10, 0, "t5b");
      finish_job("t5b");

      // 6: fairness with req0 held, req3 pulsed, req2 withdrawn
      bus.rsp_ready = 4'b1110;
      set_req(0, 1, 1);
      serve(0, 1, 1, 1, 0, 10, 1, "t6a");
      set_req(3, -1, -1);
      bus.req_valid[2] = 1'b1;
      tick();
      bus.req_valid[2] = 1'b0;
      tick();
      chk("t6.busyrdy", {28'h0, bus.req_ready}, 32'd0);
      bus.rsp_ready = '1;
      tick();
      chk("t6.gnt3", {28'h0, bus.req_ready}, 32'h8);
      serve(3, -1, -1, 1, 0, 10, 0, "t6b");
      finish_job("t6b");
      chk("t6.gnt0", {28'h0, bus.req_ready}, 32'h1);
      bus.req_valid = '0;
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
